// File: rtl/divider_8bit_seq.sv
// divider_8bit_seq: multi-cycle unsigned 8-bit restoring divider with start/busy/done handshake
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only while busy=0
//   dividend     in   unsigned dividend, captured when start is accepted
//   divisor      in   unsigned divisor, captured when start is accepted
//   busy         out  high while an operation is running
//   done         out  one-cycle pulse when results become valid
//   quotient     out  floor(dividend/divisor), DBZ_QUOT on divide-by-zero
//   remainder    out  dividend mod divisor, dividend on divide-by-zero
//   div_by_zero  out  set with done when divisor was 0, held with the results
module subtractor_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_diff
);
    assign o_diff = i_a - i_b;
endmodule

module divider_8bit_seq #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] DBZ_QUOT = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t           r_state, w_next;
    logic             r_pend;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_q, r_r, r_div, r_quot, r_rem;
    logic             r_dbz;
    logic             w_accept, w_ge;
    logic [WIDTH:0]   w_s;
    logic [WIDTH-1:0] w_diff, w_r_next, w_q_next;
    // r_pend marks the single idle cycle between a divide-by-zero request and its done pulse
    assign w_accept = start && r_state != S_RUN && !r_pend;
    assign w_s      = {r_r, r_q[WIDTH-1]};
    assign w_ge     = w_s >= {1'b0, r_div};
    subtractor_8bit u_sub (
        .i_a    (w_s[WIDTH-1:0]),
        .i_b    (r_div),
        .o_diff (w_diff)
    );
    // when w_s[8] is set the true difference still fits in 8 bits, so the wrapped diff is exact
    assign w_r_next = w_ge ? w_diff : w_s[WIDTH-1:0];
    assign w_q_next = {r_q[WIDTH-2:0], w_ge};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_accept && divisor != '0)
            w_next = S_RUN;
        else if (r_pend)
            w_next = S_DONE;
        else if (r_state == S_RUN)
            w_next = r_cnt == 3'(WIDTH - 1) ? S_DONE : S_RUN;
        else if (r_state == S_DONE)
            w_next = S_IDLE;
    end
    always_comb begin
        busy        = r_state == S_RUN;
        done        = r_state == S_DONE;
        quotient    = r_quot;
        remainder   = r_rem;
        div_by_zero = r_dbz;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_q <= dividend;
            if (divisor != '0) begin
                r_r   <= '0;
                r_div <= divisor;
                r_cnt <= '0;
                r_dbz <= 1'b0;
            end else begin
                r_pend <= 1'b1;
            end
        end else if (r_pend) begin
            r_pend <= 1'b0;
            r_quot <= DBZ_QUOT;
            r_rem  <= r_q;
            r_dbz  <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_r   <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'(WIDTH - 1)) begin
                r_quot <= w_q_next;
                r_rem  <= w_r_next;
            end
        end
    end
endmodule

// File: tb/tb_divider_8bit_seq.sv
// tb_divider_8bit_seq: randomized self-checking bench for divider_8bit_seq
module tb_divider_8bit_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;
    int checks = 0, errors = 0;

    divider_8bit_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_q(input int a, input int b);
        return b == 0 ? 8'hFF : 8'(a / b);
    endfunction
    function automatic logic [7:0] ref_r(input int a, input int b);
        return b == 0 ? 8'(a) : 8'(a % b);
    endfunction

    // Issue one request and count edges until done; also notes busy sightings and busy&done overlap.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                          output bit saw_busy, output bit overlap);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; saw_busy = busy; overlap = busy && done;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            saw_busy |= busy;
            overlap  |= busy && done;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat; bit sb, ov;
        int a_t[4] = '{200, 255, 255, 5};
        int b_t[4] = '{7, 1, 255, 10};
        for (int i = 0; i < 4; i++) begin
            run_op(8'(a_t[i]), 8'(b_t[i]), lat, sb, ov);
            checks++;
            if (lat !== 8 || quotient !== ref_q(a_t[i], b_t[i]) ||
                remainder !== ref_r(a_t[i], b_t[i]) || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL basic %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b, required lat=8 q=%0d r=%0d dbz=0",
                         a_t[i], b_t[i], lat, quotient, remainder, div_by_zero,
                         ref_q(a_t[i], b_t[i]), ref_r(a_t[i], b_t[i]));
            end
        end
    endtask

    task automatic test_div_by_zero;
        int lat; bit sb, ov;
        run_op(8'd100, 8'd0, lat, sb, ov);
        checks++;
        if (lat !== 1 || sb || quotient !== 8'hFF || remainder !== 8'd100 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_by_zero: lat=%0d busy_seen=%b q=%h r=%0d dbz=%b, required lat=1 busy_seen=0 q=ff r=100 dbz=1",
                     lat, sb, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_hold: done=%b dbz=%b, required done=0 dbz=1", done, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        dividend = 8'd200; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_clear: busy=%b dbz=%b, required busy=1 dbz=0", busy, div_by_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 8'd9; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        lat = 3;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 8 || quotient !== 8'd28 || remainder !== 8'd4) begin
            errors++;
            $display("FAIL busy_ignore: lat=%0d q=%0d r=%0d, required lat=8 q=28 r=4", lat, quotient, remainder);
        end
        dividend = 8'd9; divisor = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'd77; divisor = 8'd0;
        checks++;
        if (busy !== 1'b1 || quotient !== 8'd28 || remainder !== 8'd4) begin
            errors++;
            $display("FAIL done_accept: busy=%b q=%0d r=%0d, required busy=1 q=28 r=4 held", busy, quotient, remainder);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 8 || quotient !== 8'd3 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL back_to_back: lat=%0d q=%0d r=%0d, required lat=8 q=3 r=0", lat, quotient, remainder);
        end
    endtask

    task automatic test_async_reset;
        int lat; bit sb, ov;
        @(negedge clk);
        dividend = 8'd135; divisor = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (10) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: done=%b, required 0", done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd135, 8'd10, lat, sb, ov);
        checks++;
        if (lat !== 8 || quotient !== 8'd13 || remainder !== 8'd5) begin
            errors++;
            $display("FAIL after_reset: lat=%0d q=%0d r=%0d, required lat=8 q=13 r=5", lat, quotient, remainder);
        end
    endtask

    task automatic test_random;
        int lat, a, b; bit sb, ov;
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 255));
            b = (i % 40 == 0) ? 0 : int'($urandom_range(1, 255));
            run_op(8'(a), 8'(b), lat, sb, ov);
            checks++;
            if (lat !== (b == 0 ? 1 : 8) || quotient !== ref_q(a, b) || remainder !== ref_r(a, b) ||
                div_by_zero !== (b == 0) || ov) begin
                errors++;
                $display("FAIL random %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b overlap=%b, required lat=%0d q=%0d r=%0d dbz=%b overlap=0",
                         a, b, lat, quotient, remainder, div_by_zero, ov,
                         b == 0 ? 1 : 8, ref_q(a, b), ref_r(a, b), b == 0);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || quotient !== ref_q(a, b) || remainder !== ref_r(a, b)) begin
                errors++;
                $display("FAIL random_pulse %0d/%0d: done=%b q=%0d r=%0d, required done=0 and results held",
                         a, b, done, quotient, remainder);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_by_zero;
        test_back_to_back;
        test_async_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
